// File: rtl/axis_match_stream.sv
// AXI-Stream front end for the feature-matching core: registered pixel path with
// line/pixel tracking, plus a match-record FIFO serialised into AXI-Stream packets.
module axis_match_stream #(
    parameter int DATA_W     = 32,
    parameter int MATCH_W    = 40,
    parameter int FIFO_DEPTH = 16,
    parameter int LINE_PIX   = 720,
    parameter int DEDUP      = 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     core_tdata,
    output logic                  core_tvalid,
    input  logic                  core_tready,
    input  logic                  core_match_valid,
    input  logic [MATCH_W-1:0]    core_match_data,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  line_irq,
    output logic [15:0]           pix_cnt,
    output logic [15:0]           line_cnt,
    output logic [15:0]           ovf_cnt,
    output logic                  ovf_sticky
);

    localparam int NBEATS     = (MATCH_W + DATA_W - 1) / DATA_W;
    localparam int KEEP_W     = DATA_W / 8;
    localparam int unsigned LAST_BYTES = (MATCH_W - (NBEATS - 1) * DATA_W + 7) / 8;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int BW         = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int SR_W       = NBEATS * DATA_W;
    localparam logic [15:0] LAST_PIX = 16'(LINE_PIX - 1);

    // ---------------- input skid buffer ----------------
    logic [DATA_W-1:0] skid_data;
    logic              skid_vld;
    logic              skid_nxt;
    logic              in_rdy;
    logic              in_acc;
    logic              main_free;

    assign s_axis_tready = in_rdy;
    assign in_acc        = s_axis_tvalid & in_rdy;
    assign main_free     = ~core_tvalid | core_tready;

    always_comb begin
        skid_nxt = skid_vld;
        if (main_free) skid_nxt = skid_vld & in_acc;
        else           skid_nxt = skid_vld | in_acc;
    end

    // in_rdy mirrors !skid_vld but stays low while in reset
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            core_tdata  <= '0;
            core_tvalid <= 1'b0;
            skid_data   <= '0;
            skid_vld    <= 1'b0;
            in_rdy      <= 1'b0;
        end else begin
            if (main_free) begin
                if (skid_vld) begin
                    core_tdata  <= skid_data;
                    core_tvalid <= 1'b1;
                    if (in_acc) skid_data <= s_axis_tdata;
                end else begin
                    core_tvalid <= in_acc;
                    if (in_acc) core_tdata <= s_axis_tdata;
                end
            end else if (in_acc) begin
                skid_data <= s_axis_tdata;
            end
            skid_vld <= skid_nxt;
            in_rdy   <= ~skid_nxt;
        end
    end

    // ---------------- pixel / line tracking ----------------
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            line_irq <= 1'b0;
        end else begin
            line_irq <= 1'b0;
            if (in_acc) begin
                if (s_axis_tuser) begin
                    pix_cnt  <= 16'd1;
                    line_cnt <= '0;
                end else if (pix_cnt == LAST_PIX) begin
                    pix_cnt  <= '0;
                    line_cnt <= line_cnt + 16'd1;
                    line_irq <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- match FIFO ----------------
    logic [MATCH_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [MATCH_W-1:0] last_rec;
    logic               last_vld;
    logic               fifo_empty, fifo_full, fifo_pop;
    logic               dup, wr_req, wr_en, drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign dup        = (DEDUP != 0) && last_vld && (core_match_data == last_rec);
    assign wr_req     = core_match_valid & ~dup;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign wr_en      = wr_req & (~fifo_full | fifo_pop);
    assign drop       = wr_req & fifo_full & ~fifo_pop;

    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) mem[wr_ptr] <= core_match_data;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_rec   <= '0;
            last_vld   <= 1'b0;
            ovf_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                last_rec <= core_match_data;
                last_vld <= 1'b1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf_sticky <= 1'b1;
                if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

    // ---------------- serialiser ----------------
    typedef enum logic {S_IDLE, S_SEND} state_t;
    state_t          state, state_nxt;
    logic [SR_W-1:0] sreg;
    logic [BW-1:0]   beat_idx;
    logic            last_beat, load, adv;
    logic [KEEP_W-1:0] keep_last;

    assign last_beat     = (beat_idx == BW'(NBEATS - 1));
    assign m_axis_tvalid = (state == S_SEND);
    assign m_axis_tdata  = sreg[DATA_W-1:0];
    assign m_axis_tlast  = m_axis_tvalid & last_beat;

    always_comb begin
        keep_last = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) keep_last[i] = (i < LAST_BYTES);
    end

    always_comb begin
        m_axis_tkeep = '0;
        if (m_axis_tvalid) m_axis_tkeep = last_beat ? keep_last : '1;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load      = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (!last_beat) begin
                        adv = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        load     = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state    <= S_IDLE;
            sreg     <= '0;
            beat_idx <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                sreg     <= SR_W'(mem[rd_ptr]);
                beat_idx <= '0;
            end else if (adv) begin
                sreg     <= sreg >> DATA_W;
                beat_idx <= beat_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_match_stream.sv
// Directed self-checking bench for axis_match_stream; a DEDUP=0 twin shares the inputs.
module tb_axis_match_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tuser, core_tready, mv, m_tready;
    logic [39:0] md;

    logic        s_tready, core_tvalid, m_tlast, m_tvalid, line_irq, ovf_sticky;
    logic [31:0] core_tdata, m_tdata;
    logic [3:0]  m_tkeep;
    logic [15:0] pix_cnt, line_cnt, ovf_cnt;

    logic        b_s_tready, b_core_tvalid, b_m_tlast, b_m_tvalid, b_line_irq, b_ovf_sticky;
    logic [31:0] b_core_tdata, b_m_tdata;
    logic [3:0]  b_m_tkeep;
    logic [15:0] b_pix_cnt, b_line_cnt, b_ovf_cnt;

    axis_match_stream dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
        .s_axis_tready(s_tready), .core_tdata(core_tdata), .core_tvalid(core_tvalid),
        .core_tready(core_tready), .core_match_valid(mv), .core_match_data(md),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .line_irq(line_irq),
        .pix_cnt(pix_cnt), .line_cnt(line_cnt), .ovf_cnt(ovf_cnt), .ovf_sticky(ovf_sticky)
    );

    axis_match_stream #(.DEDUP(0)) dut_nodedup (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
        .s_axis_tready(b_s_tready), .core_tdata(b_core_tdata), .core_tvalid(b_core_tvalid),
        .core_tready(core_tready), .core_match_valid(mv), .core_match_data(md),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready), .line_irq(b_line_irq),
        .pix_cnt(b_pix_cnt), .line_cnt(b_line_cnt), .ovf_cnt(b_ovf_cnt), .ovf_sticky(b_ovf_sticky)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [39:0] rec;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    beat_t       mq[$];
    logic [31:0] cq[$];
    int          cyc = 0;
    int          b_recs = 0;
    int          irq_cnt = 0;
    int          gaps = 0;
    bit          thru_win = 1'b0;
    bit          rand_rdy = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_tvalid && m_tready) mq.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast, cyc: cyc});
        if (core_tvalid && core_tready) cq.push_back(core_tdata);
        if (b_m_tvalid && m_tready && b_m_tlast) b_recs <= b_recs + 1;
        if (line_irq) irq_cnt <= irq_cnt + 1;
        if (thru_win && core_tready && !core_tvalid) gaps <= gaps + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) core_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_mvalid(input string nm);
        int n;
        n = 0;
        while (!m_tvalid && n < 50) begin
            tick();
            n++;
        end
        chk(nm, m_tvalid, 1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic u);
        bit acc;
        acc = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = s_tready;
            tick();
        end
        if (!acc) begin
            errors++;
            $display("FAIL s_tready_timeout: got 0 expected 1");
        end
    endtask

    function automatic logic [39:0] rec_of(input int i);
        return {mq[2*i+1].d[7:0], mq[2*i].d};
    endfunction

    task automatic chk_reset_zero(input string nm);
        chk({nm, "_a"}, {s_tready, core_tvalid, core_tdata, m_tvalid, m_tlast, m_tkeep, m_tdata, line_irq}, 0);
        chk({nm, "_a_cnt"}, {pix_cnt, line_cnt, ovf_cnt, ovf_sticky}, 0);
        chk({nm, "_b"}, {b_s_tready, b_core_tvalid, b_core_tdata, b_m_tvalid, b_m_tlast, b_m_tkeep,
                         b_m_tdata, b_line_irq}, 0);
        chk({nm, "_b_cnt"}, {b_pix_cnt, b_line_cnt, b_ovf_cnt, b_ovf_sticky}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[4];
        int   base, mism;
        tbl[0] = '{rec: 40'h12_3456_789A, lo: 32'h3456_789A, hi: 32'h0000_0012};
        tbl[1] = '{rec: 40'hAB_CDEF_0123, lo: 32'hCDEF_0123, hi: 32'h0000_00AB};
        tbl[2] = '{rec: 40'hFF_FFFF_FFFF, lo: 32'hFFFF_FFFF, hi: 32'h0000_00FF};
        tbl[3] = '{rec: 40'h00_0000_0001, lo: 32'h0000_0001, hi: 32'h0000_0000};

        rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0;
        core_tready = 1'b1; mv = 1'b0; md = '0; m_tready = 1'b1;
        #13;
        chk_reset_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("ready_after_reset", s_tready, 1);

        // back-to-back records, full-rate output
        mq.delete();
        for (int i = 0; i < 4; i++) begin
            mv = 1'b1; md = tbl[i].rec;
            tick();
        end
        mv = 1'b0;
        repeat (20) tick();
        chk("t1_nbeats", mq.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_lo%0d", i), {mq[2*i].d, mq[2*i].k, mq[2*i].l}, {tbl[i].lo, 4'hF, 1'b0});
            chk($sformatf("t1_hi%0d", i), {mq[2*i+1].d, mq[2*i+1].k, mq[2*i+1].l}, {tbl[i].hi, 4'h1, 1'b1});
        end
        mism = 0;
        for (int j = 1; j < 8; j++) if (mq[j].cyc != mq[j-1].cyc + 1) mism++;
        chk("t1_no_gap", mism, 0);

        // backpressure on the last beat
        mq.delete();
        m_tready = 1'b0;
        mv = 1'b1; md = 40'h77_1122_3344;
        tick();
        mv = 1'b0;
        wait_mvalid("bp_valid");
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d", k), {m_tdata, m_tkeep, m_tlast, m_tvalid}, {32'h77, 4'h1, 1'b1, 1'b1});
            tick();
        end
        m_tready = 1'b1;
        repeat (5) tick();
        chk("bp_nbeats", mq.size(), 2);
        chk("bp_beat0", {mq[0].d, mq[0].k, mq[0].l}, {32'h1122_3344, 4'hF, 1'b0});
        chk("bp_beat1", {mq[1].d, mq[1].k, mq[1].l}, {32'h77, 4'h1, 1'b1});

        // dedup: 5,5,6,5
        mq.delete();
        base = b_recs;
        mv = 1'b1; md = 40'h5; tick();
        md = 40'h5; tick();
        md = 40'h6; tick();
        md = 40'h5; tick();
        mv = 1'b0;
        repeat (30) tick();
        chk("dd_nbeats", mq.size(), 6);
        chk("dd_rec0", rec_of(0), 40'h5);
        chk("dd_rec1", rec_of(1), 40'h6);
        chk("dd_rec2", rec_of(2), 40'h5);
        chk("dd_off_recs", b_recs - base, 4);

        // overflow: a primer record sits in the serialiser so the FIFO itself sees all 20
        mq.delete();
        chk("ovf_pre", {ovf_cnt, ovf_sticky}, 0);
        m_tready = 1'b0;
        mv = 1'b1; md = 40'hEE_0000_0000; tick();
        mv = 1'b0;
        wait_mvalid("ovf_primer_valid");
        for (int i = 0; i < 20; i++) begin
            mv = 1'b1; md = 40'h10_0000_0000 + 40'(i);
            tick();
        end
        mv = 1'b0;
        tick();
        chk("ovf_cnt", ovf_cnt, 4);
        chk("ovf_sticky", ovf_sticky, 1);
        m_tready = 1'b1;
        tick();
        mv = 1'b1; md = 40'h99_0000_0042;   // lands as the full FIFO is popped
        tick();
        mv = 1'b0;
        repeat (60) tick();
        chk("ovf_nbeats", mq.size(), 36);
        chk("ovf_primer", rec_of(0), 40'hEE_0000_0000);
        mism = 0;
        for (int i = 0; i < 16; i++) if (rec_of(i + 1) !== 40'h10_0000_0000 + 40'(i)) mism++;
        chk("ovf_order", mism, 0);
        chk("ovf_full_rw", rec_of(17), 40'h99_0000_0042);
        chk("ovf_cnt_after", ovf_cnt, 4);

        // line counting
        base = irq_cnt;
        for (int i = 0; i < 1440; i++) begin
            send_beat(32'(i), i == 0);
            if (i == 719)  chk("irq_719", line_irq, 1);
            if (i == 720)  chk("irq_720", line_irq, 0);
            if (i == 1439) chk("irq_1439", line_irq, 1);
        end
        s_tvalid = 1'b0;
        tick();
        chk("irq_count", irq_cnt - base, 2);
        chk("line_after_2", {line_cnt, pix_cnt}, {16'd2, 16'd0});
        send_beat(32'hAAAA, 1'b1);
        s_tvalid = 1'b0;
        chk("sof_restart", {line_cnt, pix_cnt}, {16'd0, 16'd1});
        for (int i = 1; i < 719; i++) send_beat(32'(i), 1'b0);
        s_tvalid = 1'b0;
        chk("pix_719", pix_cnt, 719);
        base = irq_cnt;
        send_beat(32'hBBBB, 1'b1);
        s_tvalid = 1'b0;
        chk("sof_wins", {line_cnt, pix_cnt, line_irq}, {16'd0, 16'd1, 1'b0});
        tick();
        chk("sof_wins_noirq", irq_cnt - base, 0);

        // input path under random core_tready
        repeat (3) tick();
        cq.delete();
        base = gaps;
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_beat(32'hC000_0000 + 32'(i), 1'b0);
            if (i == 3) thru_win = 1'b1;
        end
        thru_win = 1'b0;
        s_tvalid = 1'b0;
        rand_rdy = 1'b0;
        core_tready = 1'b1;
        repeat (10) tick();
        chk("core_count", cq.size(), 300);
        mism = 0;
        for (int i = 0; i < 300; i++) if (cq[i] !== 32'hC000_0000 + 32'(i)) mism++;
        chk("core_order", mism, 0);
        chk("core_thruput", gaps - base, 0);

        // asynchronous reset mid-packet
        mq.delete();
        m_tready = 1'b0;
        mv = 1'b1; md = 40'h55_AAAA_BBBB; tick();
        mv = 1'b0;
        wait_mvalid("rst_pkt_valid");
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        chk("rst_mid_pkt", {m_tvalid, m_tlast}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        mq.delete();
        m_tready = 1'b1;
        mv = 1'b1; md = 40'hCC_1234_5678; tick();
        mv = 1'b0;
        repeat (6) tick();
        chk("post_rst_nbeats", mq.size(), 2);
        chk("post_rst_beat0", {mq[0].d, mq[0].k, mq[0].l}, {32'h1234_5678, 4'hF, 1'b0});
        chk("post_rst_beat1", {mq[1].d, mq[1].k, mq[1].l}, {32'h0000_00CC, 4'h1, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
